active_list: RTL and testbench
==============================

Name: active_list

Overview:
- In-order retirement buffer on the receiving end of the rename stage's pairing interface.
- Each renamed instruction deposits {logical reg, new physical reg, previous physical reg}.
- Entries are marked done by writeback and committed strictly in order. On commit, the superseded physical register is returned to the rename free list.
- On a branch flush, younger entries are walked back one per cycle so the map table can be restored and their new physical registers freed.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- LREG_W, 5, logical register index width.
- PREG_W, 6, physical register index width (64 physical regs).
- IDX_W, $clog2(DEPTH), entry tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- alloc_valid  input  1  rename presents an entry.
- alloc_ready  output  1  entry accepted this cycle when alloc_valid&&alloc_ready.
- alloc_logical  input  LREG_W  destination logical reg (prev_logical_reg).
- alloc_prev_preg  input  PREG_W  previous mapping (prev_physical_reg).
- alloc_new_preg  input  PREG_W  newly allocated physical reg.
- alloc_tag  output  IDX_W  tag given to the accepted entry (= tail pointer).
- wb_valid  input  1  writeback completion.
- wb_tag  input  IDX_W  tag being marked done.
- flush  input  1  squash all entries younger than flush_tag.
- flush_tag  input  IDX_W  youngest surviving entry (the branch).
- free_valid  output  1  physical reg returned to free list.
- free_preg  output  PREG_W  reg being freed.
- restore_valid  output  1  map table restore request.
- restore_logical  output  LREG_W  logical reg to restore.
- restore_preg  output  PREG_W  physical reg to write back into the map.
- count  output  IDX_W+1  occupied entries.
- busy  output  1  high while in ROLLBACK.

Behaviour:
- Storage is a circular buffer with head (oldest), tail (next free) and count. Per entry: valid, done, logical, prev_preg, new_preg. Pointers wrap modulo DEPTH.
- Reset (rst_n=0 at posedge) clears:
  - head, tail and count to 0.
  - All valid and done bits to 0.
  - state to NORMAL.
  - free_valid, restore_valid and busy to 0; free_preg, restore_logical and restore_preg to 0.
- Reset overrides everything, including a rollback in progress.
- All outputs except alloc_ready and alloc_tag are registered.
- alloc_ready = (state==NORMAL) && (count<DEPTH) && !flush. It is derived from registered count, so a same-cycle commit does not open a slot.
- Allocate: the entry is written at tail with done=0; tail++ and count++.
- Writeback: wb_valid sets done[wb_tag] if valid[wb_tag]; otherwise it is ignored. Writeback is honoured in every state, including the flush cycle.
- Commit (NORMAL only): if valid[head] && done[head], one entry per cycle:
  - Next cycle: free_valid=1 and free_preg=prev_preg[head].
  - valid[head] is cleared, head++ and count--.
- Allocate and commit in the same cycle leave count unchanged.
- A head entry marked done by wb in cycle N commits at the earliest in cycle N+1, with free_valid in N+2.
- State NORMAL, on flush:
  - If valid[flush_tag]: target=flush_tag and go to ROLLBACK. No commit and no alloc that cycle.
  - Otherwise flush is a no-op.
- State ROLLBACK: each cycle, let e = tail-1.
  - If e==target: return to NORMAL; no output pulse.
  - Otherwise, next cycle:
    - restore_valid=1, restore_logical=logical[e], restore_preg=prev_preg[e].
    - free_valid=1, free_preg=new_preg[e].
    - Clear valid[e], tail--, count--.
- Flush with nothing younger than flush_tag costs one cycle in ROLLBACK and produces no pulses.
- Commit is stalled throughout ROLLBACK, so the free port is never contended.
- flush during ROLLBACK: target is updated only if the new flush_tag is older, i.e. ((flush_tag-head) mod DEPTH) < ((target-head) mod DEPTH) and it is valid. Otherwise it is ignored.
- busy = (state==ROLLBACK).
- Full: count==DEPTH holds alloc_ready low. head==tail is disambiguated by count.

Test Plan:
- Reset, then allocate 3 entries (logical 1/2/3, prev 1/2/3, new 32/33/34), wb tags 0,1,2 -> free_preg 1,2,3 on consecutive cycles; count returns to 0.
- DEPTH=16: allocate 16 entries with no wb -> alloc_ready=0 at count=16. Then wb tag 0 -> one commit, alloc_ready=1 the following cycle. Tail wraps to 0.
- Out-of-order wb: allocate tags 0..2, wb 2 then 1 -> no free_valid; wb 0 -> frees tags 0,1,2 in order on 3 consecutive cycles.
- Allocate tags 0..4, flush_tag=1 -> busy for 4 cycles; restore pulses for tags 4,3,2 (restore_preg=their prev_preg, free_preg=their new_preg); count=2; alloc_tag=2 afterwards.
- Flush_tag=4 with tail=5 -> busy 1 cycle, no pulses. A flush on an invalid tag -> ignored.
- Assert rst_n=0 mid-rollback -> next cycle busy=0, count=0, no pulses; a subsequent alloc receives tag 0.

Source files
------------

// File: rtl/active_list.sv
// In-order retirement buffer for renamed instructions.
// Accepts {logical, new preg, prev preg} from rename, marks entries done on
// writeback and retires them in program order. Each retirement returns the
// superseded physical register to the free list. On a branch flush, entries
// younger than the branch are unwound one per cycle from the tail. Each unwind
// step asks for a map-table restore and frees the speculative physical register.
module active_list #(
    parameter int DEPTH  = 16,
    parameter int LREG_W = 5,
    parameter int PREG_W = 6,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [LREG_W-1:0] alloc_logical,
    input  logic [PREG_W-1:0] alloc_prev_preg,
    input  logic [PREG_W-1:0] alloc_new_preg,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_tag,
    input  logic              flush,
    input  logic [IDX_W-1:0]  flush_tag,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    output logic              restore_valid,
    output logic [LREG_W-1:0] restore_logical,
    output logic [PREG_W-1:0] restore_preg,
    output logic [IDX_W:0]    count,
    output logic              busy
);

    typedef enum logic {
        NORMAL   = 1'b0,
        ROLLBACK = 1'b1
    } state_t;

    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   COUNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] target;
    logic [IDX_W-1:0] target_next;
    logic [IDX_W:0]   count_next;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;

    logic [LREG_W-1:0] logical_mem [DEPTH];
    logic [PREG_W-1:0] prev_mem    [DEPTH];
    logic [PREG_W-1:0] new_mem     [DEPTH];

    logic             alloc_fire;
    logic             commit_fire;
    logic             pop_fire;
    logic             flush_hit;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] flush_age;
    logic [IDX_W-1:0] target_age;

    // Rename handshake works from registered count, so a commit in the same
    // cycle never opens a slot early.
    assign alloc_ready = (state == NORMAL) && (count < FULL_COUNT) && !flush;
    assign alloc_tag   = tail;
    assign busy        = (state == ROLLBACK);

    // Youngest occupied entry, and ages measured from the oldest entry so that
    // "older" is well defined across pointer wrap.
    assign last_idx   = tail - IDX_ONE;
    assign flush_hit  = flush && valid[flush_tag];
    assign flush_age  = flush_tag - head;
    assign target_age = target - head;

    // Next-state logic: decides allocate, commit and unwind for this cycle.
    always_comb begin
        state_next  = state;
        target_next = target;
        alloc_fire  = 1'b0;
        commit_fire = 1'b0;
        pop_fire    = 1'b0;
        case (state)
            NORMAL: begin
                if (flush_hit) begin
                    // Branch mispredict: freeze retirement and start unwinding.
                    state_next  = ROLLBACK;
                    target_next = flush_tag;
                end else begin
                    alloc_fire  = alloc_valid && alloc_ready;
                    commit_fire = valid[head] && done[head];
                end
            end
            ROLLBACK: begin
                pop_fire = (last_idx != target);
                if (flush_hit && (flush_age < target_age)) begin
                    // An older branch also mispredicted: unwind further. Staying
                    // here even when the old target was just reached keeps the
                    // newer flush from being lost.
                    target_next = flush_tag;
                end else if (!pop_fire) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    // Occupancy bookkeeping: allocate and retire/unwind can cancel out.
    always_comb begin
        count_next = count;
        if (alloc_fire) begin
            count_next = count_next + COUNT_ONE;
        end
        if (commit_fire || pop_fire) begin
            count_next = count_next - COUNT_ONE;
        end
    end

    // State and rollback target registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= NORMAL;
            target <= '0;
        end else begin
            state  <= state_next;
            target <= target_next;
        end
    end

    // Head, tail and occupancy pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (commit_fire) begin
                head <= head + IDX_ONE;
            end
            if (alloc_fire) begin
                tail <= tail + IDX_ONE;
            end else if (pop_fire) begin
                tail <= last_idx;
            end
            count <= count_next;
        end
    end

    // Per-entry valid/done flags; later assignments in this block take priority
    // so an entry being retired or unwound is cleared even if written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            done  <= '0;
        end else begin
            if (wb_valid && valid[wb_tag]) begin
                done[wb_tag] <= 1'b1;
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
            end
            if (commit_fire) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (pop_fire) begin
                valid[last_idx] <= 1'b0;
                done[last_idx]  <= 1'b0;
            end
        end
    end

    // Entry payload storage; only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            logical_mem[tail] <= alloc_logical;
            prev_mem[tail]    <= alloc_prev_preg;
            new_mem[tail]     <= alloc_new_preg;
        end
    end

    // Registered free-list and map-restore ports. Retirement and unwinding
    // never happen in the same cycle, so the free port has a single source.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_valid      <= 1'b0;
            free_preg       <= '0;
            restore_valid   <= 1'b0;
            restore_logical <= '0;
            restore_preg    <= '0;
        end else begin
            free_valid    <= commit_fire || pop_fire;
            restore_valid <= pop_fire;
            if (commit_fire) begin
                free_preg <= prev_mem[head];
            end else if (pop_fire) begin
                free_preg <= new_mem[last_idx];
            end
            if (pop_fire) begin
                restore_logical <= logical_mem[last_idx];
                restore_preg    <= prev_mem[last_idx];
            end
        end
    end

endmodule

// File: tb/tb_active_list.sv
// Testbench for active_list: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_active_list;

    localparam int DEPTH  = 16;
    localparam int LREG_W = 5;
    localparam int PREG_W = 6;
    localparam int IDX_W  = 4;
    localparam int X      = -1;

    logic              clk;
    logic              rst_n;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [LREG_W-1:0] alloc_logical;
    logic [PREG_W-1:0] alloc_prev_preg;
    logic [PREG_W-1:0] alloc_new_preg;
    logic [IDX_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_tag;
    logic              flush;
    logic [IDX_W-1:0]  flush_tag;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              restore_valid;
    logic [LREG_W-1:0] restore_logical;
    logic [PREG_W-1:0] restore_preg;
    logic [IDX_W:0]    count;
    logic              busy;

    active_list #(
        .DEPTH (DEPTH),
        .LREG_W(LREG_W),
        .PREG_W(PREG_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_logical  (alloc_logical),
        .alloc_prev_preg(alloc_prev_preg),
        .alloc_new_preg (alloc_new_preg),
        .alloc_tag      (alloc_tag),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .flush          (flush),
        .flush_tag      (flush_tag),
        .free_valid     (free_valid),
        .free_preg      (free_preg),
        .restore_valid  (restore_valid),
        .restore_logical(restore_logical),
        .restore_preg   (restore_preg),
        .count          (count),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int l;
        int p;
        int n;
        bit d;
    } ent_t;

    typedef struct {
        int rdy;
        int tag;
        int fv;
        int fp;
        int rv;
        int rl;
        int rp;
        int cnt;
        int bsy;
    } exp_t;

    ent_t mq[$];
    int   mhead = 0;
    bit   mrb   = 1'b0;
    int   mtgt  = 0;

    function automatic int age(input int t);
        return (t - mhead + DEPTH) % DEPTH;
    endfunction

    function automatic exp_t model_step(input bit av, input int lg, input int pp, input int np,
                                        input bit wv, input int wt, input bit fl, input int ft);
        exp_t e;
        ent_t t;
        int   sz     = mq.size();
        int   wi     = age(wt);
        int   fi     = age(ft);
        bit   commit = 1'b0;
        bit   pop    = 1'b0;
        e = '{default: 0};
        e.rdy = (!mrb && sz < DEPTH && !fl) ? 1 : 0;
        e.tag = (mhead + sz) % DEPTH;
        if (!mrb) begin
            if (fl && fi < sz) begin
                mrb  = 1'b1;
                mtgt = fi;
            end else begin
                commit = (sz > 0) && mq[0].d;
            end
        end else begin
            pop = (sz - 1 != mtgt);
            if (fl && fi < sz && fi < mtgt) mtgt = fi;
            else if (!pop) mrb = 1'b0;
        end
        if (wv && wi < sz) begin
            t = mq[wi];
            t.d = 1'b1;
            mq[wi] = t;
        end
        if (commit) begin
            e.fv = 1;
            e.fp = mq[0].p;
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
        end
        if (pop) begin
            e.fv = 1;
            e.fp = mq[sz-1].n;
            e.rv = 1;
            e.rl = mq[sz-1].l;
            e.rp = mq[sz-1].p;
            void'(mq.pop_back());
        end
        if (e.rdy == 1 && av) begin
            t.l = lg;
            t.p = pp;
            t.n = np;
            t.d = 1'b0;
            mq.push_back(t);
        end
        e.cnt = mq.size();
        e.bsy = mrb ? 1 : 0;
        return e;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int rs, av, lg, pp, np, wv, wt, fl, ft;
        int rdy, tag, fv, fp, rv, rl, rp, cnt, bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int rs, input int av, input int lg, input int pp, input int np,
                                input int wv, input int wt, input int fl, input int ft,
                                input int rdy, input int tag, input int fv, input int fp,
                                input int rv, input int rl, input int rp, input int cnt, input int bsy);
        vec_t v;
        v = '{rs, av, lg, pp, np, wv, wt, fl, ft, rdy, tag, fv, fp, rv, rl, rp, cnt, bsy};
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        alloc_valid     = 1'b0;
        alloc_logical   = '0;
        alloc_prev_preg = '0;
        alloc_new_preg  = '0;
        wb_valid        = 1'b0;
        wb_tag          = '0;
        flush           = 1'b0;
        flush_tag       = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mq.delete();
        mhead = 0;
        mrb   = 1'b0;
        mtgt  = 0;
        chk("reset.count", count, 0);
        chk("reset.busy", busy, 0);
    endtask

    task automatic alloc_one(input int lg, input int pp, input int np);
        alloc_valid     = 1'b1;
        alloc_logical   = LREG_W'(lg);
        alloc_prev_preg = PREG_W'(pp);
        alloc_new_preg  = PREG_W'(np);
        step();
        alloc_valid     = 1'b0;
    endtask

    exp_t e;

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // Commit in order after writeback.
        add(1,0,0,0,0, 0,0,0,0, X,X, 0,0,0,0,0,0,0);
        add(0,1,1,1,32, 0,0,0,0, 1,0, 0,X,0,X,X,1,0);
        add(0,1,2,2,33, 0,0,0,0, 1,1, 0,X,0,X,X,2,0);
        add(0,1,3,3,34, 0,0,0,0, 1,2, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 1,0,0,0, 1,3, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 1,1,0,0, 1,3, 1,1,0,X,X,2,0);
        add(0,0,0,0,0, 1,2,0,0, 1,3, 1,2,0,X,X,1,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 1,3,0,X,X,0,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 0,X,0,X,X,0,0);
        // Out-of-order writeback.
        add(1,0,0,0,0, 0,0,0,0, X,X, 0,0,0,0,0,0,0);
        add(0,1,4,7,50, 0,0,0,0, 1,0, 0,X,0,X,X,1,0);
        add(0,1,5,8,51, 0,0,0,0, 1,1, 0,X,0,X,X,2,0);
        add(0,1,6,9,52, 0,0,0,0, 1,2, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 1,2,0,0, 1,3, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 1,1,0,0, 1,3, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 1,0,0,0, 1,3, 0,X,0,X,X,3,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 1,7,0,X,X,2,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 1,8,0,X,X,1,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 1,9,0,X,X,0,0);
        add(0,0,0,0,0, 0,0,0,0, 1,3, 0,X,0,X,X,0,0);
        // Flush to tag 1 with tags 0..4 live, then short and ignored flushes.
        add(1,0,0,0,0, 0,0,0,0, X,X, 0,0,0,0,0,0,0);
        add(0,1,10,5,40, 0,0,0,0, 1,0, 0,X,0,X,X,1,0);
        add(0,1,11,6,41, 0,0,0,0, 1,1, 0,X,0,X,X,2,0);
        add(0,1,12,7,42, 0,0,0,0, 1,2, 0,X,0,X,X,3,0);
        add(0,1,13,8,43, 0,0,0,0, 1,3, 0,X,0,X,X,4,0);
        add(0,1,14,9,44, 0,0,0,0, 1,4, 0,X,0,X,X,5,0);
        add(0,1,0,0,0, 0,0,1,1, 0,5, 0,X,0,X,X,5,1);
        add(0,0,0,0,0, 0,0,0,0, 0,5, 1,44,1,14,9,4,1);
        add(0,0,0,0,0, 0,0,0,0, 0,4, 1,43,1,13,8,3,1);
        add(0,0,0,0,0, 0,0,0,0, 0,3, 1,42,1,12,7,2,1);
        add(0,0,0,0,0, 0,0,0,0, 0,2, 0,X,0,X,X,2,0);
        add(0,1,20,21,50, 0,0,0,0, 1,2, 0,X,0,X,X,3,0);
        add(0,1,21,22,51, 0,0,0,0, 1,3, 0,X,0,X,X,4,0);
        add(0,1,22,23,52, 0,0,0,0, 1,4, 0,X,0,X,X,5,0);
        add(0,0,0,0,0, 0,0,1,4, 0,5, 0,X,0,X,X,5,1);
        add(0,0,0,0,0, 0,0,0,0, 0,5, 0,X,0,X,X,5,0);
        add(0,1,1,1,1, 0,0,1,7, 0,5, 0,X,0,X,X,5,0);
        add(0,0,0,0,0, 0,0,0,0, 1,5, 0,X,0,X,X,5,0);

        foreach (vecs[i]) begin
            rst_n           = (vecs[i].rs == 0);
            alloc_valid     = vecs[i].av[0];
            alloc_logical   = vecs[i].lg[LREG_W-1:0];
            alloc_prev_preg = vecs[i].pp[PREG_W-1:0];
            alloc_new_preg  = vecs[i].np[PREG_W-1:0];
            wb_valid        = vecs[i].wv[0];
            wb_tag          = vecs[i].wt[IDX_W-1:0];
            flush           = vecs[i].fl[0];
            flush_tag       = vecs[i].ft[IDX_W-1:0];
            #1;
            if (vecs[i].rdy >= 0) chk($sformatf("vec%0d.alloc_ready", i), alloc_ready, vecs[i].rdy);
            if (vecs[i].tag >= 0) chk($sformatf("vec%0d.alloc_tag", i), alloc_tag, vecs[i].tag);
            step();
            chk($sformatf("vec%0d.free_valid", i), free_valid, vecs[i].fv);
            if (vecs[i].fp >= 0) chk($sformatf("vec%0d.free_preg", i), free_preg, vecs[i].fp);
            chk($sformatf("vec%0d.restore_valid", i), restore_valid, vecs[i].rv);
            if (vecs[i].rl >= 0) chk($sformatf("vec%0d.restore_logical", i), restore_logical, vecs[i].rl);
            if (vecs[i].rp >= 0) chk($sformatf("vec%0d.restore_preg", i), restore_preg, vecs[i].rp);
            chk($sformatf("vec%0d.count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
        end
        drive_idle();

        // Fill to DEPTH, one commit, then the freed slot at the wrapped tail.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid     = 1'b1;
            alloc_logical   = LREG_W'(i);
            alloc_prev_preg = PREG_W'(i + 1);
            alloc_new_preg  = PREG_W'(i + 32);
            #1;
            chk($sformatf("fill%0d.alloc_ready", i), alloc_ready, 1);
            chk($sformatf("fill%0d.alloc_tag", i), alloc_tag, i);
            step();
        end
        chk("full.count", count, DEPTH);
        wb_valid = 1'b1;
        wb_tag   = '0;
        #1;
        chk("full.alloc_ready", alloc_ready, 0);
        step();
        wb_valid = 1'b0;
        chk("full_wb.count", count, DEPTH);
        #1;
        chk("commit_cycle.alloc_ready", alloc_ready, 0);
        step();
        chk("full_commit.free_valid", free_valid, 1);
        chk("full_commit.free_preg", free_preg, 1);
        chk("full_commit.count", count, DEPTH - 1);
        #1;
        chk("reopen.alloc_ready", alloc_ready, 1);
        chk("reopen.alloc_tag", alloc_tag, 0);
        step();
        alloc_valid = 1'b0;
        chk("refill.count", count, DEPTH);
        chk("refill.free_valid", free_valid, 0);

        // Reset in the middle of a rollback.
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(i, i + 2, i + 20);
        flush     = 1'b1;
        flush_tag = '0;
        step();
        flush = 1'b0;
        chk("rb_start.busy", busy, 1);
        step();
        chk("rb_pop.restore_valid", restore_valid, 1);
        chk("rb_pop.free_preg", free_preg, 23);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rb_reset.busy", busy, 0);
        chk("rb_reset.count", count, 0);
        chk("rb_reset.free_valid", free_valid, 0);
        chk("rb_reset.restore_valid", restore_valid, 0);
        alloc_valid = 1'b1;
        #1;
        chk("post_reset.alloc_tag", alloc_tag, 0);
        step();
        alloc_valid = 1'b0;
        chk("post_reset.count", count, 1);
        step();
        chk("post_reset.busy", busy, 0);
        chk("post_reset.restore_valid", restore_valid, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit av, wv, fl;
            int lg, pp, np, wt, ft;
            av = ($urandom_range(0, 9) < 7);
            wv = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 99) < 5);
            lg = int'($urandom_range(0, 31));
            pp = int'($urandom_range(0, 63));
            np = int'($urandom_range(0, 63));
            wt = int'($urandom_range(0, DEPTH - 1));
            ft = int'($urandom_range(0, DEPTH - 1));
            alloc_valid     = av;
            alloc_logical   = LREG_W'(lg);
            alloc_prev_preg = PREG_W'(pp);
            alloc_new_preg  = PREG_W'(np);
            wb_valid        = wv;
            wb_tag          = IDX_W'(wt);
            flush           = fl;
            flush_tag       = IDX_W'(ft);
            e = model_step(av, lg, pp, np, wv, wt, fl, ft);
            #1;
            chk($sformatf("rnd%0d.alloc_ready", c), alloc_ready, e.rdy);
            chk($sformatf("rnd%0d.alloc_tag", c), alloc_tag, e.tag);
            step();
            chk($sformatf("rnd%0d.free_valid", c), free_valid, e.fv);
            if (e.fv == 1) chk($sformatf("rnd%0d.free_preg", c), free_preg, e.fp);
            chk($sformatf("rnd%0d.restore_valid", c), restore_valid, e.rv);
            if (e.rv == 1) begin
                chk($sformatf("rnd%0d.restore_logical", c), restore_logical, e.rl);
                chk($sformatf("rnd%0d.restore_preg", c), restore_preg, e.rp);
            end
            chk($sformatf("rnd%0d.count", c), count, e.cnt);
            chk($sformatf("rnd%0d.busy", c), busy, e.bsy);
        end
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
